// File: rtl/fir_tap_seq_if.sv
// Bundle between the FIR tap sequencer, its sample/coefficient source, the shared
// mul_sum unit and the output consumer. The slave modport is the sequencer side.
interface fir_tap_seq_if #(
  parameter int SZin = 8,
  parameter int ADRW = 2
);
  logic                  coef_we;
  logic [ADRW-1:0]       coef_addr;
  logic [SZin:0]         coef_wdata;
  logic                  in_valid;
  logic                  in_ready;
  logic [SZin:0]         x_in;
  logic [SZin:0]         ai;
  logic [SZin:0]         xni;
  logic [2*(SZin+1)-1:0] resprev;
  logic [2*(SZin+1):0]   res;
  logic                  y_valid;
  logic [2*(SZin+1)-1:0] y;
  logic                  y_ovf;

  modport master (
    output coef_we, coef_addr, coef_wdata, in_valid, x_in, res,
    input  in_ready, ai, xni, resprev, y_valid, y, y_ovf
  );

  modport slave (
    input  coef_we, coef_addr, coef_wdata, in_valid, x_in, res,
    output in_ready, ai, xni, resprev, y_valid, y, y_ovf
  );
endinterface

// File: rtl/fir_tap_seq.sv
// Serial FIR tap sequencer: walks NTAP taps through one external multiply-accumulate
// unit (mul_sum) and emits one filtered output per accepted sample.
module fir_tap_seq #(
  parameter int SZin    = 8,
  parameter int NTAP    = 4,
  parameter int ADRW    = 2,
  parameter int MUL_LAT = 1
) (
  input logic          clk,
  input logic          rst,
  fir_tap_seq_if.slave bus
);
  localparam int DW = SZin + 1;
  localparam int AW = 2 * DW;
  localparam int WW = $clog2(MUL_LAT + 1);
  localparam logic [WW-1:0]   WAIT_LAST = WW'(MUL_LAT);
  localparam logic [ADRW-1:0] TAP_LAST  = ADRW'(NTAP - 1);

  typedef enum logic [1:0] {IDLE, ISSUE, DONE} state_t;

  state_t          state;
  state_t          state_nxt;
  logic [DW-1:0]   coef [NTAP];
  logic [DW-1:0]   xd   [NTAP];
  logic [AW-1:0]   acc;
  logic            ovf;
  logic [ADRW-1:0] tap;
  logic [WW-1:0]   wcnt;
  logic [AW-1:0]   y_q;
  logic            y_ovf_q;

  logic            in_ready_c;
  logic            y_valid_c;
  logic [DW-1:0]   ai_c;
  logic [DW-1:0]   xni_c;
  logic            last_beat;
  logic            coef_ok;

  assign last_beat = (state == ISSUE) && (wcnt == WAIT_LAST);
  assign coef_ok   = bus.coef_we && (state == IDLE) &&
                     ({1'b0, bus.coef_addr} < (ADRW+1)'(NTAP));

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (bus.in_valid) state_nxt = ISSUE;
      ISSUE:   if (last_beat && (tap == TAP_LAST)) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    in_ready_c = 1'b0;
    y_valid_c  = 1'b0;
    ai_c       = '0;
    xni_c      = '0;
    case (state)
      IDLE:  in_ready_c = !rst;
      ISSUE: begin
        ai_c  = coef[tap];
        xni_c = xd[tap];
      end
      DONE:  y_valid_c = 1'b1;
      default: ;
    endcase
  end

  // Operands stay put for MUL_LAT+1 cycles; the result is captured on the last one.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < NTAP; k++) begin
        coef[k] <= '0;
        xd[k]   <= '0;
      end
      acc     <= '0;
      ovf     <= 1'b0;
      tap     <= '0;
      wcnt    <= '0;
      y_q     <= '0;
      y_ovf_q <= 1'b0;
    end else begin
      if (coef_ok) coef[bus.coef_addr] <= bus.coef_wdata;
      case (state)
        IDLE: begin
          if (bus.in_valid) begin
            xd[0] <= bus.x_in;
            for (int k = 1; k < NTAP; k++) xd[k] <= xd[k-1];
            acc  <= '0;
            ovf  <= 1'b0;
            tap  <= '0;
            wcnt <= '0;
          end
        end
        ISSUE: begin
          if (last_beat) begin
            acc  <= bus.res[AW-1:0];
            ovf  <= ovf | bus.res[AW];
            wcnt <= '0;
            if (tap == TAP_LAST) begin
              y_q     <= bus.res[AW-1:0];
              y_ovf_q <= ovf | bus.res[AW];
            end else begin
              tap <= tap + 1'b1;
            end
          end else begin
            wcnt <= wcnt + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.in_ready = in_ready_c;
  assign bus.y_valid  = y_valid_c;
  assign bus.ai       = ai_c;
  assign bus.xni      = xni_c;
  assign bus.resprev  = acc;
  assign bus.y        = y_q;
  assign bus.y_ovf    = y_ovf_q;
endmodule

// File: tb/tb_fir_tap_seq.sv
// Scoreboard bench for fir_tap_seq driving a behavioural mul_sum; expected outputs
// come from a dot-product model of the filter history and coefficient table.
module tb_fir_tap_seq;
  localparam int SZin = 8;
  localparam int NTAP = 4;
  localparam int ADRW = 2;
  localparam int MUL_LAT = 1;
  localparam int AW = 2 * (SZin + 1);
  localparam int LAT = NTAP * (MUL_LAT + 1) + 1;
  localparam longint MODV = 64'd1 << AW;

  typedef struct {
    longint y;
    longint ovf;
    int     due;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   vectors = 0;
  int   miscompares = 0;
  int   pulses = 0;
  int   last_accept = 0;
  exp_t sb[$];
  exp_t mon_e;
  int   m_coef [NTAP];
  int   m_hist [NTAP];

  fir_tap_seq_if #(.SZin(SZin), .ADRW(ADRW)) fbus ();

  fir_tap_seq #(.SZin(SZin), .NTAP(NTAP), .ADRW(ADRW), .MUL_LAT(MUL_LAT)) dut (
    .clk (clk),
    .rst (rst),
    .bus (fbus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // mul_sum stand-in: one register stage, res = ai*xni + resprev with carry bit
  always @(posedge clk)
    fbus.res <= (AW+1)'(fbus.ai) * (AW+1)'(fbus.xni) + (AW+1)'(fbus.resprev);

  task automatic checkOutput(input string name, input longint act, input longint exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("[TB] FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic modelReset();
    for (int k = 0; k < NTAP; k++) begin
      m_coef[k] = 0;
      m_hist[k] = 0;
    end
    sb.delete();
  endtask

  task automatic modelAccept(input int xv);
    longint total = 0;
    exp_t e;
    for (int k = NTAP - 1; k > 0; k--) m_hist[k] = m_hist[k-1];
    m_hist[0] = xv;
    for (int k = 0; k < NTAP; k++) total += longint'(m_coef[k]) * longint'(m_hist[k]);
    e.y   = total % MODV;
    e.ovf = (total >= MODV) ? 1 : 0;
    e.due = cyc + LAT;
    sb.push_back(e);
  endtask

  task automatic writeCoef(input int addr, input int data, input bit applied);
    fbus.coef_we    = 1'b1;
    fbus.coef_addr  = ADRW'(addr);
    fbus.coef_wdata = (SZin+1)'(data);
    if (applied) m_coef[addr] = data;
    @(posedge clk); #1;
    fbus.coef_we = 1'b0;
  endtask

  // Presents a sample until the sequencer takes it; returns one step after the accept edge.
  task automatic applyStimulus(input int xv, input bit check_busy, input bit keep_valid,
                               input bit check_space);
    bit done = 1'b0;
    fbus.in_valid = 1'b1;
    fbus.x_in     = (SZin+1)'(xv);
    for (int i = 0; i < 40 && !done; i++) begin
      @(negedge clk);
      if (fbus.in_ready) begin
        if (check_space) checkOutput("accept_spacing", cyc - last_accept, LAT + 1);
        last_accept = cyc;
        modelAccept(xv);
        done = 1'b1;
      end
    end
    if (!done) checkOutput("accept_timeout", 0, 1);
    @(posedge clk); #1;
    if (!keep_valid) fbus.in_valid = 1'b0;
    if (check_busy) begin
      for (int k = 1; k <= LAT; k++) begin
        @(negedge clk);
        checkOutput("busy_in_ready", fbus.in_ready, 0);
      end
      @(negedge clk);
      checkOutput("ready_return", fbus.in_ready, 1);
      @(posedge clk); #1;
    end
  endtask

  task automatic waitDrain();
    for (int i = 0; i < 200 && sb.size() > 0; i++) @(negedge clk);
    if (sb.size() > 0) begin
      checkOutput("drain_timeout", sb.size(), 0);
      sb.delete();
    end
    @(posedge clk); #1;
  endtask

  always @(negedge clk) begin
    if (!rst && fbus.y_valid) begin
      pulses++;
      if (sb.size() == 0) begin
        checkOutput("unexpected_y_valid", 1, 0);
      end else begin
        mon_e = sb.pop_front();
        checkOutput("y", fbus.y, mon_e.y);
        checkOutput("y_ovf", fbus.y_ovf, mon_e.ovf);
        checkOutput("y_valid_cycle", cyc, mon_e.due);
      end
    end
  end

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int pulses_before;
    fbus.coef_we = 1'b0;
    fbus.coef_addr = '0;
    fbus.coef_wdata = '0;
    fbus.in_valid = 1'b0;
    fbus.x_in = '0;
    modelReset();
    repeat (3) @(posedge clk);
    @(negedge clk);
    checkOutput("in_ready_in_reset", fbus.in_ready, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    checkOutput("rst_in_ready", fbus.in_ready, 1);
    checkOutput("rst_y_valid", fbus.y_valid, 0);
    checkOutput("rst_y", fbus.y, 0);
    checkOutput("rst_y_ovf", fbus.y_ovf, 0);
    checkOutput("rst_ai", fbus.ai, 0);
    checkOutput("rst_xni", fbus.xni, 0);
    checkOutput("rst_resprev", fbus.resprev, 0);
    @(posedge clk); #1;

    $display("[TB] impulse");
    for (int k = 0; k < NTAP; k++) writeCoef(k, k + 1, 1'b1);
    applyStimulus(1, 1'b1, 1'b0, 1'b0);
    for (int k = 0; k < 3; k++) applyStimulus(0, 1'b1, 1'b0, 1'b0);
    waitDrain();

    $display("[TB] step");
    for (int k = 0; k < 4; k++) applyStimulus(5, 1'b0, 1'b0, 1'b0);
    waitDrain();

    $display("[TB] busy write ignored, idle write honoured");
    writeCoef(0, 1, 1'b1);
    for (int k = 1; k < NTAP; k++) writeCoef(k, 0, 1'b1);
    applyStimulus(2, 1'b0, 1'b0, 1'b0);
    writeCoef(0, 9, 1'b0);
    waitDrain();
    writeCoef(0, 9, 1'b1);
    applyStimulus(3, 1'b0, 1'b0, 1'b0);
    waitDrain();
    fbus.coef_we = 1'b1;
    fbus.coef_addr = 2'd1;
    fbus.coef_wdata = 9'd2;
    m_coef[1] = 2;
    applyStimulus(4, 1'b0, 1'b0, 1'b0);
    fbus.coef_we = 1'b0;
    waitDrain();

    $display("[TB] mid-operation reset");
    applyStimulus(7, 1'b0, 1'b0, 1'b0);
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b1;
    modelReset();
    @(negedge clk);
    checkOutput("in_ready_during_rst", fbus.in_ready, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    checkOutput("post_rst_in_ready", fbus.in_ready, 1);
    checkOutput("post_rst_y", fbus.y, 0);
    checkOutput("post_rst_y_ovf", fbus.y_ovf, 0);
    checkOutput("post_rst_resprev", fbus.resprev, 0);
    repeat (15) @(posedge clk);
    #1;
    for (int k = 1; k < NTAP; k++) writeCoef(k, 1, 1'b1);
    applyStimulus(4, 1'b0, 1'b0, 1'b0);
    waitDrain();
    for (int k = 0; k < 3; k++) applyStimulus(0, 1'b0, 1'b0, 1'b0);
    waitDrain();

    $display("[TB] overflow");
    for (int k = 0; k < NTAP; k++) writeCoef(k, 511, 1'b1);
    applyStimulus(511, 1'b0, 1'b0, 1'b0);
    applyStimulus(511, 1'b0, 1'b0, 1'b0);
    waitDrain();

    $display("[TB] back-to-back random");
    for (int k = 0; k < NTAP; k++) writeCoef(k, int'($urandom_range(0, 511)), 1'b1);
    pulses_before = pulses;
    for (int i = 0; i < 8; i++)
      applyStimulus(int'($urandom_range(0, 511)), 1'b0, 1'b1, i > 0);
    fbus.in_valid = 1'b0;
    waitDrain();
    repeat (12) @(posedge clk);
    checkOutput("b2b_pulse_count", pulses - pulses_before, 8);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
